e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. Executes `mult`, `multu`, `div` and `divu` over a fixed multi-cycle latency, and owns the HI/LO registers for `mfhi`, `mflo`, `mthi` and `mtlo`. It produces `Start` and `Busy`, which feed the hazard/stall unit's MDU interlock. The stall unit holds any MDU-class instruction in D while `Start | Busy`.

---
 rtl/e_mdu_pkg.sv | 26 ++
 rtl/e_mdu.sv | 120 ++++++++++++
 tb/tb_e_mdu.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings, default latencies and a decode helper.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  // True for the four operations that occupy the unit for several cycles.
  function automatic logic mdu_is_arith(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at
// start, parked in hi_tmp/lo_tmp, and committed when the countdown expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MDU_Out
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  mdu_op_e op;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d;
  logic [31:0] lo_tmp_q, lo_tmp_d;
  logic [3:0]  cnt_q, cnt_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        [31:0] divisor;
  logic               b_zero;

  assign op    = mdu_op_e'(MDUOp);
  assign Busy  = (cnt_q != 4'd0);
  assign Start = mdu_is_arith(MDUOp) && !Busy;

  // Divisor forced non-zero so the quotient never goes X; a zero divisor
  // keeps HI/LO instead of using these results.
  assign b_zero  = (B == 32'd0);
  assign divisor = b_zero ? 32'd1 : B;

  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    quot_s = 32'($signed(A) / $signed(divisor));
    rem_s  = 32'($signed(A) % $signed(divisor));
    quot_u = A / divisor;
    rem_u  = A % divisor;
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    cnt_d    = cnt_q;

    if (Start) begin
      case (op)
        MDU_MULT: begin
          {hi_tmp_d, lo_tmp_d} = prod_s;
          cnt_d                = MULT_N;
        end
        MDU_MULTU: begin
          {hi_tmp_d, lo_tmp_d} = prod_u;
          cnt_d                = MULT_N;
        end
        MDU_DIV: begin
          hi_tmp_d = b_zero ? hi_q : rem_s;
          lo_tmp_d = b_zero ? lo_q : quot_s;
          cnt_d    = DIV_N;
        end
        MDU_DIVU: begin
          hi_tmp_d = b_zero ? hi_q : rem_u;
          lo_tmp_d = b_zero ? lo_q : quot_u;
          cnt_d    = DIV_N;
        end
        default: ;
      endcase
    end else if (Busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end else begin
      // MT writes only land while idle; during an op they are dropped.
      if (op == MDU_MTHI) hi_d = A;
      if (op == MDU_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      cnt_q    <= 4'd0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    case (op)
      MDU_MFHI: MDU_Out = hi_q;
      MDU_MFLO: MDU_Out = lo_q;
      default:  MDU_Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: multiply/divide results, latency, MT/MF ordering,
// reset abort and back-to-back interlock behaviour.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] MDU_Out;

  int errors = 0;
  int checks = 0;

  e_mdu dut (
    .clk     (clk),
    .reset   (reset),
    .MDUOp   (MDUOp),
    .A       (A),
    .B       (B),
    .Start   (Start),
    .Busy    (Busy),
    .MDU_Out (MDU_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Peek committed HI/LO via MFHI/MFLO without an edge, then restore the op.
  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [3:0] saved;
    saved = MDUOp;
    MDUOp = MDU_MFHI;
    #1;
    check({tag, " HI"}, MDU_Out, exp_hi);
    MDUOp = MDU_MFLO;
    #1;
    check({tag, " LO"}, MDU_Out, exp_lo);
    MDUOp = saved;
    #1;
  endtask

  task automatic mt_write(input logic [3:0] op, input logic [31:0] val);
    MDUOp = op;
    A     = val;
    tick();
    MDUOp = MDU_NONE;
  endtask

  // Start an op, verify Busy over exactly n cycles, then check results.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_bad;
    MDUOp = op;
    A     = a;
    B     = b;
    #1;
    check({tag, " start"}, 32'(Start), 32'd1);
    tick();
    MDUOp = MDU_NONE;
    busy_bad = 0;
    for (int k = 1; k <= n; k++) begin
      if (Busy !== 1'b1) busy_bad++;
      tick();
    end
    check({tag, " busy-cycles-low"}, 32'(busy_bad), 32'd0);
    check({tag, " busy-end"}, 32'(Busy), 32'd0);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    int start_bad;
    int busy_bad;

    reset = 1'b0;
    MDUOp = MDU_NONE;
    A     = 32'd0;
    B     = 32'd0;
    tick();
    tick();
    check("rst busy", 32'(Busy), 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    MDUOp = MDU_MULT;
    #1;
    check("rst start-follows-op", 32'(Start), 32'd1);
    tick();
    check("rst busy-after-mult", 32'(Busy), 32'd0);
    MDUOp = MDU_NONE;
    reset = 1'b1;
    tick();

    run_op("mult", MDU_MULT, 32'h8000_0000, 32'd2, 5, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("multu", MDU_MULTU, 32'h8000_0000, 32'd2, 5, 32'h0000_0001, 32'h0000_0000);
    run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MDU_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);

    mt_write(MDU_MTHI, 32'h0000_1234);
    mt_write(MDU_MTLO, 32'h0000_5678);
    read_hilo("mt", 32'h0000_1234, 32'h0000_5678);
    run_op("div0", MDU_DIV, 32'd5, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);

    // MTHI presented: reads before the edge still see the old HI.
    MDUOp = MDU_MTHI;
    A     = 32'hDEAD_BEEF;
    #1;
    check("mthi out-zero", MDU_Out, 32'd0);
    read_hilo("pre-mthi", 32'h0000_1234, 32'h0000_5678);
    tick();
    MDUOp = MDU_NONE;
    read_hilo("post-mthi", 32'hDEAD_BEEF, 32'h0000_5678);

    // MT during a divide-by-zero is dropped; commit restores the old values.
    MDUOp = MDU_DIVU;
    A     = 32'd9;
    B     = 32'd0;
    tick();
    MDUOp = MDU_MTLO;
    A     = 32'hAAAA_5555;
    tick();
    MDUOp = MDU_NONE;
    for (int k = 0; k < 10; k++) tick();
    check("mt-busy busy-end", 32'(Busy), 32'd0);
    read_hilo("mt-busy", 32'hDEAD_BEEF, 32'h0000_5678);

    // Reset two cycles into a multiply aborts it.
    MDUOp = MDU_MULT;
    A     = 32'd3;
    B     = 32'd4;
    tick();
    MDUOp = MDU_NONE;
    check("abort busy-t1", 32'(Busy), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort busy-t3", 32'(Busy), 32'd0);
    read_hilo("abort t3", 32'd0, 32'd0);
    for (int k = 0; k < 6; k++) tick();
    check("abort busy-late", 32'(Busy), 32'd0);
    read_hilo("abort late", 32'd0, 32'd0);

    // Back-to-back: MULT held while DIVU runs.
    MDUOp = MDU_DIVU;
    A     = 32'd100;
    B     = 32'd7;
    #1;
    check("b2b divu start", 32'(Start), 32'd1);
    tick();
    MDUOp = MDU_MULT;
    A     = 32'd6;
    B     = 32'd7;
    start_bad = 0;
    busy_bad  = 0;
    for (int k = 1; k <= 10; k++) begin
      if (Start !== 1'b0) start_bad++;
      if (Busy !== 1'b1) busy_bad++;
      tick();
    end
    check("b2b start-held", 32'(start_bad), 32'd0);
    check("b2b busy-held", 32'(busy_bad), 32'd0);
    check("b2b mult start", 32'(Start), 32'd1);
    read_hilo("b2b divu", 32'd2, 32'd14);
    tick();
    MDUOp = MDU_NONE;
    for (int k = 0; k < 5; k++) tick();
    check("b2b busy-end", 32'(Busy), 32'd0);
    read_hilo("b2b final", 32'd0, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
